// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared defaults, FSM encoding and sizing helper for the kernel bank
package kernel_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_K      = 3;
    localparam int DEF_N_CH   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_mem.sv
// rtl/kernel_mem.sv - single-port weight RAM, one-cycle registered read
module kernel_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 144,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents must survive a reset of the surrounding control logic.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/kernel_bank.sv
// rtl/kernel_bank.sv - per-channel convolution kernel store with word-serial load and atomic fetch
module kernel_bank
    import kernel_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int K      = DEF_K,
    parameter  int N_CH   = DEF_N_CH,
    localparam int KK     = K * K,
    localparam int CH_W   = clog2_min1(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_done,
    input  logic                 c_load,
    input  logic [CH_W-1:0]      cout,
    output logic                 busy,
    output logic                 k_valid,
    output logic                 err,
    output logic [KK*DATA_W-1:0] kernel_o
);

    localparam int DEPTH = N_CH * KK;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int PW    = clog2_min1(KK);
    localparam int FW    = clog2_min1(KK + 1);

    state_t              state, state_nx;
    logic [PW-1:0]       wr_ptr;
    logic [FW-1:0]       fcnt;
    logic [CH_W-1:0]     cur_ch;
    logic [KK*DATA_W-1:0] staging;
    logic [DATA_W-1:0]   mem_rdata;
    logic [AW-1:0]       mem_addr;
    logic                mem_en, mem_we;
    logic                wr_fire, ch_ok, load_ok;

    assign wr_ready = (state == IDLE) && !c_load;
    assign wr_fire  = wr_valid && wr_ready;
    assign ch_ok    = 32'(cout) < N_CH;
    assign load_ok  = (state == IDLE) && c_load && ch_ok;
    assign busy     = (state != IDLE);

    // The port is shared: reads only happen in FETCH, writes only in IDLE.
    assign mem_en   = wr_fire || ((state == FETCH) && (fcnt < FW'(KK)));
    assign mem_we   = wr_fire && (32'(wr_ch) < N_CH);
    assign mem_addr = (state == FETCH) ? AW'(32'(cur_ch) * KK + 32'(fcnt))
                                       : AW'(32'(wr_ch) * KK + 32'(wr_ptr));

    kernel_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .en     (mem_en),
        .we     (mem_we),
        .addr   (mem_addr),
        .wdata  (wr_data),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_ok) state_nx = FETCH;
            FETCH:   if (fcnt == FW'(KK)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            fcnt     <= '0;
            cur_ch   <= '0;
            staging  <= '0;
            kernel_o <= '0;
            k_valid  <= 1'b0;
            err      <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            k_valid <= 1'b0;
            err     <= (state == IDLE) && c_load && !ch_ok;
            wr_done <= wr_fire && (wr_ptr == PW'(KK - 1));
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == PW'(KK - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (load_ok) begin
                cur_ch <= cout;
                fcnt   <= '0;
            end
            // Read data for index fcnt-1 is on mem_rdata while fcnt is counting.
            if (state == FETCH) begin
                if (fcnt != '0) begin
                    staging[(32'(fcnt) - 1) * DATA_W +: DATA_W] <= mem_rdata;
                end
                fcnt <= fcnt + 1'b1;
            end
            if (state == COMMIT) begin
                kernel_o <= staging;
                k_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kernel_bank.sv
// tb/tb_kernel_bank.sv - self-checking bench: behavioural model plus directed and random stimulus
module tb_kernel_bank;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int KK   = 9;
    localparam int NCH  = 16;
    localparam int CHW  = 4;
    localparam int DW2  = 16;
    localparam int K2   = 5;
    localparam int KK2  = 25;
    localparam int NCH2 = 12;
    localparam int CHW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic               wr_valid, wr_ready, wr_done, c_load, busy, k_valid, err;
    logic [CHW-1:0]     wr_ch, cout;
    logic [DW-1:0]      wr_data;
    logic [KK*DW-1:0]   kernel_o;

    logic               b_wr_valid, b_wr_ready, b_wr_done, b_c_load, b_busy, b_k_valid, b_err;
    logic [CHW2-1:0]    b_wr_ch, b_cout;
    logic [DW2-1:0]     b_wr_data;
    logic [KK2*DW2-1:0] b_kernel_o;

    kernel_bank #(.DATA_W(DW), .K(K), .N_CH(NCH)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .wr_data(wr_data), .wr_done(wr_done), .c_load(c_load), .cout(cout), .busy(busy),
        .k_valid(k_valid), .err(err), .kernel_o(kernel_o)
    );

    kernel_bank #(.DATA_W(DW2), .K(K2), .N_CH(NCH2)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_ch(b_wr_ch),
        .wr_data(b_wr_data), .wr_done(b_wr_done), .c_load(b_c_load), .cout(b_cout), .busy(b_busy),
        .k_valid(b_k_valid), .err(b_err), .kernel_o(b_kernel_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural model of the default-parameter instance: kernels as arrays,
    // fetch as "result appears KK+2 edges after acceptance".
    int               cyc      = 0;
    bit               cmp_en   = 0;
    bit               m_active = 0;
    int               m_commit = 0;
    int               m_ch     = 0;
    int               m_ptr    = 0;
    logic [KK*DW-1:0] m_kernel = '0;
    bit               e_kv = 0, e_err = 0, e_wd = 0;
    logic [DW-1:0]    m_mem [NCH][KK];

    always @(posedge clk) begin
        cyc++;
        e_kv  = 0;
        e_err = 0;
        e_wd  = 0;
        if (!rst) begin
            m_active = 0;
            m_ptr    = 0;
            m_kernel = '0;
        end else if (m_active) begin
            if (cyc == m_commit) begin
                for (int i = 0; i < KK; i++) m_kernel[i*DW +: DW] = m_mem[m_ch][i];
                e_kv     = 1;
                m_active = 0;
            end
        end else if (c_load) begin
            if (int'(cout) >= NCH) begin
                e_err = 1;
            end else begin
                m_active = 1;
                m_ch     = int'(cout);
                m_commit = cyc + KK + 2;
            end
        end else if (wr_valid) begin
            if (int'(wr_ch) < NCH) m_mem[wr_ch][m_ptr] = wr_data;
            e_wd  = (m_ptr == KK - 1);
            m_ptr = (m_ptr + 1) % KK;
        end
    end

    always @(negedge clk) begin
        if (rst && cmp_en) begin
            chk("busy", busy, m_active);
            chk("k_valid", k_valid, e_kv);
            chk("err", err, e_err);
            chk("wr_done", wr_done, e_wd);
            chk("wr_ready", wr_ready, !m_active && !c_load);
            chk("kernel_o", kernel_o, m_kernel);
        end
    end

    int wd_cnt = 0;
    always @(negedge clk) if (wr_done) wd_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int ch, input int data);
        bit acc;
        wr_valid = 1'b1;
        wr_ch    = CHW'(ch);
        wr_data  = DW'(data);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            acc = wr_ready;
            tick();
            if (acc) return;
        end
        chk("wr_accept_timeout", 0, 1);
    endtask

    task automatic write_kernel(input int ch, input int base, input bit rnd);
        for (int i = 0; i < KK; i++) write_word(ch, rnd ? int'($urandom_range(0, 255)) : base + i);
        wr_valid = 1'b0;
    endtask

    // Caller guarantees the block is idle; poke>0 raises a stray c_load mid-fetch.
    task automatic fetch(input int ch, input int poke, output int lat);
        c_load = 1'b1;
        cout   = CHW'(ch);
        tick();
        c_load = 1'b0;
        lat    = -1;
        for (int j = 1; j <= 40; j++) begin
            if (j == poke) begin
                c_load = 1'b1;
                cout   = 4'd0;
            end else begin
                c_load = 1'b0;
            end
            tick();
            if (k_valid) begin
                lat    = j;
                c_load = 1'b0;
                return;
            end
        end
        c_load = 1'b0;
    endtask

    initial begin
        int lat, wd0, kvs;
        bit found;
        logic [KK2*DW2-1:0] bexp;

        rst = 1'b1;
        wr_valid = 0; wr_ch = '0; wr_data = '0; c_load = 0; cout = '0;
        b_wr_valid = 0; b_wr_ch = '0; b_wr_data = '0; b_c_load = 0; b_cout = '0;
        #1 rst = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_k_valid", k_valid, 0);
        chk("reset_err", err, 0);
        chk("reset_wr_done", wr_done, 0);
        chk("reset_kernel", kernel_o, 0);
        chk("reset_b_kernel", b_kernel_o, 0);
        repeat (2) tick();
        rst    = 1'b1;
        cmp_en = 1;

        for (int c = 0; c < NCH; c++) write_kernel(c, 0, 1'b1);

        tick();
        wd0 = wd_cnt;
        write_kernel(2, 1, 1'b0);
        @(negedge clk);
        #1;
        chk("r035_wr_done_count", wd_cnt - wd0, 1);
        fetch(2, 0, lat);
        chk("r035_latency", lat, 11);
        chk("r035_kernel", kernel_o, 72'h090807060504030201);

        write_kernel(0, 10, 1'b0);
        write_kernel(15, 200, 1'b0);
        fetch(15, 4, lat);
        chk("r036_latency_15", lat, 11);
        chk("r036_kernel_15", kernel_o, 72'hD0CFCECDCCCBCAC9C8);
        fetch(0, 0, lat);
        chk("r036_latency_0", lat, 11);
        chk("r036_kernel_0", kernel_o, 72'h1211100F0E0D0C0B0A);

        c_load = 1'b1; cout = 4'd1;
        wr_valid = 1'b1; wr_ch = 4'd5; wr_data = 8'hAB;
        @(negedge clk);
        chk("r038_wr_ready_clash", wr_ready, 0);
        tick();
        c_load = 1'b0;
        @(negedge clk);
        chk("r038_wr_ready_busy", wr_ready, 0);
        found = 0;
        for (int j = 0; j < 40 && !found; j++) begin
            tick();
            if (k_valid) found = 1;
        end
        chk("r038_fetch_done", found, 1);
        tick();
        wr_valid = 1'b0;
        for (int i = 1; i < KK; i++) write_word(5, i);
        wr_valid = 1'b0;
        fetch(5, 0, lat);
        chk("r038_kernel_5", kernel_o, 72'h0807060504030201AB);

        c_load = 1'b1; cout = 4'd2;
        tick();
        c_load = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("r039_busy", busy, 0);
        chk("r039_k_valid", k_valid, 0);
        chk("r039_err", err, 0);
        chk("r039_wr_done", wr_done, 0);
        chk("r039_kernel", kernel_o, 0);
        repeat (2) tick();
        rst = 1'b1;
        kvs = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (k_valid) kvs++;
        end
        chk("r039_no_k_valid", kvs, 0);
        fetch(2, 0, lat);
        chk("r039_refetch_latency", lat, 11);
        chk("r039_refetch_kernel", kernel_o, 72'h090807060504030201);

        for (int n = 0; n < 3000; n++) begin
            c_load   = ($urandom_range(0, 7) == 0);
            cout     = CHW'($urandom);
            wr_valid = 1'($urandom);
            wr_ch    = CHW'($urandom);
            wr_data  = DW'($urandom);
            tick();
        end
        c_load = 1'b0; wr_valid = 1'b0;
        repeat (20) tick();

        for (int i = 0; i < KK2; i++) begin
            b_wr_valid = 1'b1; b_wr_ch = 4'd13; b_wr_data = 16'hFFFF;
            tick();
        end
        b_wr_valid = 1'b0;
        chk("b_discard_wr_done", b_wr_done, 1);
        for (int i = 0; i < KK2; i++) begin
            b_wr_valid = 1'b1; b_wr_ch = 4'd2; b_wr_data = DW2'(i + 1);
            if (i == 0) begin
                @(negedge clk);
                chk("b_wr_ready", b_wr_ready, 1);
            end
            tick();
            chk("b_wr_done", b_wr_done, i == KK2 - 1);
        end
        b_wr_valid = 1'b0;

        b_c_load = 1'b1; b_cout = 4'd2;
        tick();
        b_c_load = 1'b0;
        lat = -1;
        for (int j = 1; j <= 60 && lat < 0; j++) begin
            tick();
            if (b_k_valid) lat = j;
        end
        chk("r040_latency", lat, 27);
        for (int i = 0; i < KK2; i++) bexp[i*DW2 +: DW2] = DW2'(i + 1);
        chk("r040_kernel", b_kernel_o, bexp);

        tick();
        b_c_load = 1'b1; b_cout = 4'd13;
        @(negedge clk);
        chk("r037_wr_ready", b_wr_ready, 0);
        tick();
        b_c_load = 1'b0;
        chk("r037_err", b_err, 1);
        chk("r037_busy", b_busy, 0);
        chk("r037_kernel", b_kernel_o, bexp);
        tick();
        chk("r037_err_drop", b_err, 0);
        chk("r037_busy_after", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
